glb_access_arbiter: RTL

//  Shares the single-port global buffer (GLB) between three requesters: 0 = DRAM loader (writes),
//  1 = PE array (reads ifmap/weight/bias), 2 = PPU (writes ofmap).

---
 rtl/glb_access_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/glb_access_arbiter.sv
// glb_access_arbiter: round-robin burst arbiter sharing one GLB port between DRAM loader, PE array and PPU.
// Optional wait-cycle counters are added when GLB_ARB_PERF_EN is defined.
module glb_access_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16,
   parameter int RD_LAT    = 1,
   parameter int IDLE_REL  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            req,
   input  logic [2:0]            we,
   input  logic [2:0]            last,
   input  logic [3*ADDR_W-1:0]   addr,
   input  logic [3*DATA_W-1:0]   wdata,
`ifdef GLB_ARB_PERF_EN
   input  logic                  perf_clr,
   output logic [47:0]           perf_wait,
`endif
   output logic [2:0]            gnt,
   output logic [2:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  glb_en,
   output logic                  glb_we,
   output logic [ADDR_W-1:0]     glb_addr,
   output logic [DATA_W-1:0]     glb_wdata,
   input  logic [DATA_W-1:0]     glb_rdata
);
   localparam int BW = $clog2(MAX_BURST);
   localparam int IW = $clog2(IDLE_REL + 1);
   typedef enum logic {S_IDLE, S_BURST} state_t;
   state_t              r_state;
   logic [1:0]          r_owner;
   logic [1:0]          r_rr;
   logic [BW-1:0]       r_beat_cnt;
   logic [IW-1:0]       r_idle_cnt;
   logic [RD_LAT-1:0]   r_pv;
   logic [2*RD_LAT-1:0] r_pid;
   logic                w_beat;
   logic                w_rel;
   logic                w_push;
   logic [1:0]          w_c1;
   logic [1:0]          w_c2;
   logic [1:0]          w_pick;
   logic [1:0]          w_rr_next;
   logic [RD_LAT:0]     w_vch;
   logic [2*RD_LAT+1:0] w_ich;
   assign w_beat    = (r_state == S_BURST) & req[r_owner];
   assign w_rel     = (w_beat & (last[r_owner] | (r_beat_cnt == BW'(MAX_BURST - 1))))
                    | ((r_state == S_BURST) & ~req[r_owner] & (r_idle_cnt == IW'(IDLE_REL - 1)));
   assign w_push    = w_beat & ~we[r_owner];
   assign w_c1      = (r_rr == 2'd2) ? 2'd0 : r_rr + 2'd1;
   assign w_c2      = (r_rr == 2'd0) ? 2'd2 : r_rr - 2'd1;
   assign w_pick    = req[r_rr] ? r_rr : req[w_c1] ? w_c1 : w_c2;
   assign w_rr_next = (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
   // read-id pipe: one stage per cycle of GLB read latency, drains independently of arbitration
   assign w_vch     = {r_pv, w_push};
   assign w_ich     = {r_pid, r_owner};
   assign gnt       = w_beat ? 3'b001 << r_owner : 3'b000;
   assign glb_en    = w_beat;
   assign glb_we    = w_beat & we[r_owner];
   assign glb_addr  = addr[r_owner*ADDR_W +: ADDR_W];
   assign glb_wdata = wdata[r_owner*DATA_W +: DATA_W];
   assign rvalid    = r_pv[RD_LAT-1] ? 3'b001 << r_pid[2*RD_LAT-1 -: 2] : 3'b000;
   assign rdata     = glb_rdata;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_owner    <= '0;
         r_rr       <= '0;
         r_beat_cnt <= '0;
         r_idle_cnt <= '0;
         r_pv       <= '0;
         r_pid      <= '0;
      end else begin
         r_pv  <= w_vch[RD_LAT-1:0];
         r_pid <= w_ich[2*RD_LAT-1:0];
         if (r_state == S_IDLE) begin
            if (|req) begin
               r_owner <= w_pick;
               r_state <= S_BURST;
            end
         end else if (w_rel) begin
            r_state    <= S_IDLE;
            r_rr       <= w_rr_next;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
         end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_idle_cnt <= '0;
         end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end
      end
   end
`ifdef GLB_ARB_PERF_EN
   logic [47:0] r_perf_wait;
   logic [2:0]  w_wait;
   assign w_wait    = req & ~gnt;
   assign perf_wait = r_perf_wait;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_wait <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (perf_clr)
               r_perf_wait[k*16 +: 16] <= '0;
            else if (w_wait[k] && r_perf_wait[k*16 +: 16] != 16'hFFFF)
               r_perf_wait[k*16 +: 16] <= r_perf_wait[k*16 +: 16] + 16'd1;
         end
      end
   end
`endif
endmodule
